// File: rtl/pad_ring_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pad_ring_pkg : shared scan command encoding and pad-ring defaults     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pad_ring_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE    = 2'b00,
    SCAN_CAPTURE = 2'b01,
    SCAN_SHIFT   = 2'b10,
    SCAN_UPDATE  = 2'b11
  } scan_cmd_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_MAX    = 4;
  localparam int CNT_W           = 4;

endpackage
`default_nettype wire

// File: rtl/pad_in_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pad_in_cell : one input channel, synchroniser plus optional glitch    |
// | filter (filter present only with PAD_RING_FILTER_EN). Rev 1.0         |
// +----------------------------------------------------------------------+
module pad_in_cell
  import pad_ring_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_MAX    = DEF_FILT_MAX
) (
  input  logic CLK,
  input  logic RESET,
  input  logic pad_i,
`ifdef PAD_RING_FILTER_EN
  input  logic filt_en_i,
`endif
  output logic core_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef PAD_RING_FILTER_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic             en_q;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (!filt_en_i) begin
      // Track the synced level so re-enabling the filter starts from it.
      filt_d = synced;
    end else if (synced != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      en_q   <= filt_en_i;
    end
  end

  assign core_o = en_q ? filt_q : synced;
`else
  assign core_o = synced;
`endif

endmodule
`default_nettype wire

// File: rtl/pad_ring_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pad_ring_ctrl : registered pad ring with input filtering and a        |
// | capture/shift/update scan chain. Macro: PAD_RING_FILTER_EN. Rev 1.0   |
// +----------------------------------------------------------------------+
module pad_ring_ctrl
  import pad_ring_pkg::*;
#(
  parameter int N_IN        = 13,
  parameter int N_OUT       = 29,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_MAX    = DEF_FILT_MAX
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_IN-1:0]  pad_in,
  input  logic [N_IN-1:0]  filt_mask,
  output logic [N_IN-1:0]  core_in,
  input  logic [N_OUT-1:0] core_out,
  input  logic [N_OUT-1:0] core_oe,
  output logic [N_OUT-1:0] pad_out,
  output logic [N_OUT-1:0] pad_oe,
  input  logic             TEST_MODE,
  input  logic [1:0]       SCAN_CMD,
  input  logic             SCAN_SI,
  output logic             SCAN_SO
);

  localparam int L = N_IN + N_OUT;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      pad_in_cell #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_MAX   (FILT_MAX)
      ) u_cell (
        .CLK      (CLK),
        .RESET    (RESET),
        .pad_i    (pad_in[gi]),
`ifdef PAD_RING_FILTER_EN
        .filt_en_i(filt_mask[gi]),
`endif
        .core_o   (core_in[gi])
      );
    end
  endgenerate

`ifndef PAD_RING_FILTER_EN
  logic unused_filt_mask;
  assign unused_filt_mask = ^filt_mask;
`endif

  scan_cmd_t        cmd;
  logic [L-1:0]     chain_q, chain_d;
  logic [N_OUT-1:0] upd_q, upd_d;
  logic [N_OUT-1:0] pad_out_q, pad_oe_q;

  // Scan commands outside test mode, including the cycle TEST_MODE drops, are idle.
  assign cmd = TEST_MODE ? scan_cmd_t'(SCAN_CMD) : SCAN_IDLE;

  always_comb begin
    chain_d = chain_q;
    upd_d   = upd_q;
    case (cmd)
      SCAN_CAPTURE: chain_d = {core_in, core_out};
      SCAN_SHIFT:   chain_d = {SCAN_SI, chain_q[L-1:1]};
      SCAN_UPDATE:  upd_d   = chain_q[N_OUT-1:0];
      default:      ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      chain_q   <= '0;
      upd_q     <= '0;
      pad_out_q <= '0;
      pad_oe_q  <= '0;
    end else begin
      chain_q <= chain_d;
      upd_q   <= upd_d;
      if (TEST_MODE) begin
        pad_out_q <= upd_q;
        pad_oe_q  <= '1;
      end else begin
        pad_out_q <= core_out;
        pad_oe_q  <= core_oe;
      end
    end
  end

  assign pad_out = pad_out_q;
  assign pad_oe  = pad_oe_q;
  assign SCAN_SO = chain_q[0];

endmodule
`default_nettype wire

// File: tb/tb_pad_ring_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pad_ring_ctrl : directed self-checking bench for pad_ring_ctrl     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pad_ring_ctrl;

  localparam int N_IN  = 13;
  localparam int N_OUT = 29;
  localparam int L     = N_IN + N_OUT;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [N_IN-1:0]  pad_in;
  logic [N_IN-1:0]  filt_mask;
  logic [N_IN-1:0]  core_in;
  logic [N_OUT-1:0] core_out;
  logic [N_OUT-1:0] core_oe;
  logic [N_OUT-1:0] pad_out;
  logic [N_OUT-1:0] pad_oe;
  logic             TEST_MODE;
  logic [1:0]       SCAN_CMD;
  logic             SCAN_SI;
  logic             SCAN_SO;

  int checks = 0;
  int errors = 0;

  logic [L-1:0] cap_exp;

  pad_ring_ctrl u_dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .pad_in   (pad_in),
    .filt_mask(filt_mask),
    .core_in  (core_in),
    .core_out (core_out),
    .core_oe  (core_oe),
    .pad_out  (pad_out),
    .pad_oe   (pad_oe),
    .TEST_MODE(TEST_MODE),
    .SCAN_CMD (SCAN_CMD),
    .SCAN_SI  (SCAN_SI),
    .SCAN_SO  (SCAN_SO)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET     = 1'b1;
    pad_in    = '0;
    filt_mask = 13'h0002;
    core_out  = '0;
    core_oe   = '0;
    TEST_MODE = 1'b0;
    SCAN_CMD  = 2'b00;
    SCAN_SI   = 1'b0;

    // Reset state before any clock edge
    #2;
    check("rst_core_in", 64'(core_in), 64'h0);
    check("rst_pad_out", 64'(pad_out), 64'h0);
    check("rst_pad_oe",  64'(pad_oe),  64'h0);
    check("rst_so",      64'(SCAN_SO), 64'h0);
    cyc(1);
    RESET = 1'b0;
    cyc(2);

    // Unfiltered channel 0: two-edge latency
    pad_in[0] = 1'b1;
    cyc(1);
    check("unf_edge1", 64'(core_in[0]), 64'h0);
    cyc(1);
    check("unf_edge2", 64'(core_in[0]), 64'h1);

`ifdef PAD_RING_FILTER_EN
    // Filtered channel 1: 3-cycle pulse suppressed
    pad_in[1] = 1'b1;
    cyc(3);
    pad_in[1] = 1'b0;
    cyc(8);
    check("filt_short", 64'(core_in[1]), 64'h0);
    // 6-cycle pulse passes at edge 6, falls six edges after release
    pad_in[1] = 1'b1;
    cyc(5);
    check("filt_e5", 64'(core_in[1]), 64'h0);
    cyc(1);
    check("filt_e6", 64'(core_in[1]), 64'h1);
    pad_in[1] = 1'b0;
    cyc(5);
    check("filt_fall5", 64'(core_in[1]), 64'h1);
    cyc(1);
    check("filt_fall6", 64'(core_in[1]), 64'h0);
`else
    // Without the filter, mask is ignored and the pulse passes straight through
    pad_in[1] = 1'b1;
    cyc(1);
    check("nofilt_e1", 64'(core_in[1]), 64'h0);
    cyc(1);
    check("nofilt_e2", 64'(core_in[1]), 64'h1);
    pad_in[1] = 1'b0;
    cyc(2);
    check("nofilt_fall", 64'(core_in[1]), 64'h0);
`endif

    // Functional output path
    core_out = 29'h1A5A_5A5A;
    core_oe  = 29'h0000_FFFF;
    cyc(1);
    check("func_pad_out", 64'(pad_out), 64'h1A5A_5A5A);
    check("func_pad_oe",  64'(pad_oe),  64'h0000_FFFF);

    // Scan: capture, 42 shifts, update
    filt_mask = '0;
    pad_in    = 13'h0055;
    core_out  = 29'h0F0F_0F0F;
    cyc(4);
    check("core_in_55", 64'(core_in), 64'h0055);
    TEST_MODE = 1'b1;
    SCAN_CMD  = 2'b01;
    cyc(1);
    cap_exp  = {13'h0055, 29'h0F0F_0F0F};
    SCAN_CMD = 2'b10;
    for (int k = 0; k < L; k++) begin
      SCAN_SI = (k % 2 == 0);
      check($sformatf("so_bit%0d", k), 64'(SCAN_SO), 64'(cap_exp[k]));
      cyc(1);
    end
    SCAN_CMD = 2'b11;
    cyc(1);
    SCAN_CMD = 2'b00;
    cyc(1);
    check("upd_pad_out", 64'(pad_out), 64'h1555_5555);
    check("upd_pad_oe",  64'(pad_oe),  64'h1FFF_FFFF);

    // One more shift makes the chain differ from upd_reg
    SCAN_CMD = 2'b10;
    SCAN_SI  = 1'b1;
    cyc(1);
    // Update in the cycle TEST_MODE falls is ignored
    TEST_MODE = 1'b0;
    SCAN_CMD  = 2'b11;
    core_out  = 29'h0123_4567;
    core_oe   = 29'h1F00_00FF;
    cyc(1);
    check("fall_pad_out", 64'(pad_out), 64'h0123_4567);
    check("fall_pad_oe",  64'(pad_oe),  64'h1F00_00FF);
    TEST_MODE = 1'b1;
    SCAN_CMD  = 2'b00;
    cyc(1);
    check("fall_upd_kept", 64'(pad_out), 64'h1555_5555);

    // Reset asserted mid-shift clears everything without a clock edge
    SCAN_CMD = 2'b10;
    SCAN_SI  = 1'b1;
    cyc(2);
    #2;
    RESET = 1'b1;
    #1;
    check("mid_core_in", 64'(core_in), 64'h0);
    check("mid_pad_out", 64'(pad_out), 64'h0);
    check("mid_pad_oe",  64'(pad_oe),  64'h0);
    check("mid_so",      64'(SCAN_SO), 64'h0);
    #1;
    RESET    = 1'b0;
    SCAN_CMD = 2'b00;
    cyc(1);
    check("post_rst_pad_out", 64'(pad_out), 64'h0);
    check("post_rst_pad_oe",  64'(pad_oe),  64'h1FFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
